// File: rtl/display_scan_controller_if.sv
// Byte-stream input and scan outputs of the 4-digit display controller.
// The controller uses the slave modport; the stream source and display side use master.
interface display_scan_controller_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       clear;
  logic [7:0] char_out;
  logic [3:0] an;
  logic [1:0] digit_idx;

  modport master (
    output char_in, char_valid, clear,
    input  char_out, an, digit_idx
  );

  modport slave (
    input  char_in, char_valid, clear,
    output char_out, an, digit_idx
  );
endinterface

// File: rtl/display_scan_controller.sv
// 4-digit 7-segment scan controller: 4-character scrolling text buffer plus
// a round-robin digit scan with an optional all-off blanking gap between digits.
module display_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input logic                      clk,
  input logic                      reset,
  display_scan_controller_if.slave bus
);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES)
                           ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                           : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] BACKSPACE  = 8'h08;

  typedef enum logic {SHOW, BLANK} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [1:0]    sel_idx;
  logic [3:0]    an_reg, an_next;
  logic [7:0]    char_reg;
  logic [7:0]    buf_reg  [4];
  logic [7:0]    push_val [4];
  logic [7:0]    bs_val   [4];
  logic          is_bs;

  assign is_bs = (bus.char_in == BACKSPACE);

  // Push shifts toward the leftmost digit; backspace shifts back toward digit 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      if (gi == 0) begin : g_push_lo
        assign push_val[gi] = bus.char_in;
      end else begin : g_push_hi
        assign push_val[gi] = buf_reg[gi-1];
      end
      if (gi == 3) begin : g_bs_hi
        assign bs_val[gi] = BLANK_CHAR;
      end else begin : g_bs_lo
        assign bs_val[gi] = buf_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || bus.clear) begin
        buf_reg[i] <= BLANK_CHAR;
      end else if (bus.char_valid) begin
        buf_reg[i] <= is_bs ? bs_val[i] : push_val[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    case (state_reg)
      SHOW: begin
        if (cnt_reg == SHOW_LAST) begin
          cnt_next = '0;
          if (BLANK_CYCLES == 0) begin
            idx_next = idx_reg + 2'd1;
          end else begin
            state_next = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          cnt_next   = '0;
          idx_next   = idx_reg + 2'd1;
          state_next = SHOW;
        end
      end
      default: begin
        state_next = SHOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are computed from next-cycle state so char_out lines up with an;
  // while blanking, char_out already carries the upcoming digit's character.
  always_comb begin
    an_next = 4'b1111;
    sel_idx = idx_next;
    if (state_next == SHOW) begin
      an_next = ~(4'b0001 << idx_next);
    end else begin
      sel_idx = idx_reg + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SHOW;
      cnt_reg   <= '0;
      idx_reg   <= 2'd0;
      an_reg    <= 4'b1110;
      char_reg  <= BLANK_CHAR;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      an_reg    <= an_next;
      char_reg  <= buf_reg[sel_idx];
    end
  end

  assign bus.char_out  = char_reg;
  assign bus.an        = an_reg;
  assign bus.digit_idx = idx_reg;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: a cycle-number based model checks
// two instances (with and without blanking) every cycle, plus literal spot checks.
module tb_display_scan_controller;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       clear;

  int vectors     = 0;
  int miscompares = 0;

  display_scan_controller_if bus2 ();
  display_scan_controller_if bus0 ();

  assign bus2.char_in    = char_in;
  assign bus2.char_valid = char_valid;
  assign bus2.clear      = clear;
  assign bus0.char_in    = char_in;
  assign bus0.char_valid = char_valid;
  assign bus0.clear      = clear;

  display_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus2)
  );
  display_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  always #5 clk = ~clk;

  // Model: position in the frame follows from the cycle number since reset.
  function automatic int exp_dig(int t, int b);
    return (t % (4 * (R + b))) / (R + b);
  endfunction

  function automatic logic is_lit(int t, int b);
    return ((t % (4 * (R + b))) % (R + b)) < R;
  endfunction

  function automatic logic [3:0] exp_an(int t, int b);
    logic [3:0] one;
    one = 4'b0001;
    if (is_lit(t, b)) return ~(one << exp_dig(t, b));
    return 4'b1111;
  endfunction

  function automatic int char_idx(int t, int b);
    if (is_lit(t, b)) return exp_dig(t, b);
    return (exp_dig(t, b) + 1) % 4;
  endfunction

  int         t = 0;
  logic       mvalid = 1'b0;
  logic [7:0] mq [$];          // mq[0] is the rightmost digit
  logic [7:0] exp_c2, exp_c0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        t = 0;
        mvalid = 1'b1;
        mq = '{8'h20, 8'h20, 8'h20, 8'h20};
        exp_c2 = 8'h20;
        exp_c0 = 8'h20;
      end else if (mvalid) begin
        t++;
        exp_c2 = mq[char_idx(t, 2)];
        exp_c0 = mq[char_idx(t, 0)];
        if (clear) begin
          mq = '{8'h20, 8'h20, 8'h20, 8'h20};
        end else if (char_valid && char_in == 8'h08) begin
          void'(mq.pop_front());
          mq.push_back(8'h20);
        end else if (char_valid) begin
          mq.push_front(char_in);
          void'(mq.pop_back());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%h want=%h", name, t, got, want);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("an_b2",    8'(bus2.an),        8'(exp_an(t, 2)));
        chk("idx_b2",   8'(bus2.digit_idx), 8'(exp_dig(t, 2)));
        chk("char_b2",  bus2.char_out,      exp_c2);
        chk("an_b0",    8'(bus0.an),        8'(exp_an(t, 0)));
        chk("idx_b0",   8'(bus0.digit_idx), 8'(exp_dig(t, 0)));
        chk("char_b0",  bus0.char_out,      exp_c0);
      end
    end
  end

  function automatic logic [3:0] hexval(byte c);
    if (c >= "A") return 4'(c - "A" + 10);
    return 4'(c - "0");
  endfunction

  task automatic push(input logic [7:0] c);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] pat, input string name);
    for (int k = 0; k < 100; k++) begin
      if (bus2.an == pat) return;
      @(negedge clk);
    end
    miscompares++;
    vectors++;
    $display("FAIL wait_%s timeout got=%b want=%b", name, bus2.an, pat);
  endtask

  task automatic check_digit(input int d, input logic [7:0] want);
    logic [3:0] one;
    one = 4'b0001;
    wait_an(~(one << d), $sformatf("digit%0d", d));
    chk($sformatf("digit%0d_char", d), bus2.char_out, want);
  endtask

  string seq;

  initial begin
    reset      = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    clear      = 1'b0;
    seq = "EEEEFFDDDDFFBBBBFF7777FFEEEEFF";
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle scan after reset, pinned against a literal anode sequence.
    for (int i = 0; i < 30; i++) begin
      chk("idle_an", 8'(bus2.an), 8'(hexval(seq[i])));
      chk("idle_char", bus2.char_out, 8'h20);
      if (i == 3) chk("noblank_an3", 8'(bus0.an), 8'(4'b1110));
      if (i == 4) chk("noblank_an4", 8'(bus0.an), 8'(4'b1101));
      @(negedge clk);
    end

    push("A"); push("b"); push("1"); push("?");
    repeat (2) @(negedge clk);
    check_digit(3, 8'h41);
    check_digit(2, 8'h62);
    check_digit(1, 8'h31);
    check_digit(0, 8'h3F);

    push("W");
    repeat (2) @(negedge clk);
    check_digit(0, 8'h57);
    check_digit(3, 8'h62);

    push(8'h08);
    repeat (2) @(negedge clk);
    check_digit(3, 8'h20);
    check_digit(2, 8'h62);
    check_digit(0, 8'h3F);

    clear = 1'b1;
    push("Z");
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check_digit(0, 8'h20);
    check_digit(2, 8'h20);

    // Push on the first lit cycle of digit 0; char_out follows two cycles later.
    wait_an(4'b1111, "blank_before0");
    wait_an(4'b1110, "lit0");
    push("Q");
    chk("midlit_an1", 8'(bus2.an), 8'(4'b1110));
    chk("midlit_char1", bus2.char_out, 8'h20);
    @(negedge clk);
    chk("midlit_an2", 8'(bus2.an), 8'(4'b1110));
    chk("midlit_char2", bus2.char_out, "Q");

    // Reset during digit 2's blanking gap.
    wait_an(4'b1011, "lit2");
    wait_an(4'b1111, "blank2");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_an", 8'(bus2.an), 8'(4'b1110));
    chk("rst_idx", 8'(bus2.digit_idx), 8'd0);
    chk("rst_char", bus2.char_out, 8'h20);
    chk("rst_an_b0", 8'(bus0.an), 8'(4'b1110));
    repeat (2) @(negedge clk);
    check_digit(0, 8'h20);
    check_digit(1, 8'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexing controller for the 4-digit 7-segment display. It holds a 4-character text buffer fed by a byte stream, for example the UART receiver. It scans the digits round-robin with a blanking gap between digits to prevent ghosting, and presents one ASCII character at a time to the shared `charTo7Segment` decoder together with the matching active-low anode select.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: cycles each digit is lit (1 kHz per digit at 100 MHz); legal range is 1 or more.
- `BLANK_CYCLES`, default 16: cycles all anodes are off between digits; 0 means no blanking state.

Ports:
- `clk` input, 1 bit: single clock; everything is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `char_in` input, 8 bits: ASCII byte to push.
- `char_valid` input, 1 bit: single-cycle push strobe; the block is always ready, with no backpressure.
- `clear` input, 1 bit: blanks the whole buffer.
- `char_out` output, 8 bits: registered ASCII code for the digit currently selected; drives the decoder `char` input.
- `an` output, 4 bits: registered, active-low anode select; `an[0]` is the rightmost digit.
- `digit_idx` output, 2 bits: registered index of the digit currently or last selected.

## Operation
- Buffer `buf[0..3]`; `buf[0]` is the rightmost digit. The blank code is 8'h20 (space), which the decoder renders as all segments off.
- Push, when `char_valid` is high and `char_in` is not 8'h08: `buf[3]<=buf[2]`, `buf[2]<=buf[1]`, `buf[1]<=buf[0]`, `buf[0]<=char_in`. Text scrolls left and the oldest character is discarded.
- Backspace, when `char_valid` is high and `char_in` is 8'h08: `buf[0]<=buf[1]`, `buf[1]<=buf[2]`, `buf[2]<=buf[3]`, `buf[3]<=8'h20`.
- `clear`: all `buf` entries become 8'h20. If `clear` and `char_valid` are high in the same cycle, `clear` wins and the character is dropped.
- Scan FSM:
  - States are SHOW and BLANK, with a cycle counter `cnt` of width $clog2(max(REFRESH_DIV, BLANK_CYCLES, 2)).
  - SHOW: `an` = ~(1<<`digit_idx`). `cnt` counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 the FSM goes to BLANK, or, if BLANK_CYCLES = 0, advances `digit_idx` and stays in SHOW. `cnt` resets to 0.
  - BLANK: `an` = 4'b1111. `cnt` counts 0..BLANK_CYCLES-1. At BLANK_CYCLES-1, `digit_idx` advances and the FSM goes to SHOW with `cnt` = 0.
  - `digit_idx` advances 0→1→2→3→0, wrapping modulo 4.
- `char_out` is reloaded every cycle from `buf` at the index that `digit_idx` will hold next cycle, so it is always aligned with `an`. A push or clear is visible on `char_out` one cycle after the buffer update, including in the middle of a digit's lit period.
- During BLANK, `char_out` keeps the character of the next digit, so the value is settled before that digit's anode turns on.

## Timing
- Reset values:
  - Every `buf` entry is 8'h20.
  - State is SHOW, `cnt` = 0, `digit_idx` = 0.
  - `an` = 4'b1110, `char_out` = 8'h20.
- Reset is synchronous. Asserting it mid-scan or mid-push restores all of the above on the next edge and discards any push presented in the same cycle.
- The first cycle after `reset` deasserts is cycle 0:
  - Digit 0 is lit during cycles 0..REFRESH_DIV-1.
  - Blanking occupies cycles REFRESH_DIV..REFRESH_DIV+BLANK_CYCLES-1.
  - Digit 1 is lit starting at cycle REFRESH_DIV+BLANK_CYCLES.
- Digit period is REFRESH_DIV+BLANK_CYCLES cycles; frame period is 4× that.
- Buffer update latency: `char_valid` sampled at edge N updates `buf` at N. The new character appears on `char_out` at N+1 if its digit is the one selected then.
- Pushes on consecutive cycles are all accepted; there is no rate limit.
- Exactly zero or one bit of `an` is low in any cycle.

## Test plan
Parameters for these tests: REFRESH_DIV = 4, BLANK_CYCLES = 2.
- Reset, then 30 idle cycles → `an` sequence is 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, 1111×2, then 1110 again. `char_out` stays 8'h20 throughout.
- Push "A", "b", "1", "?" on consecutive cycles → `buf[3..0]` holds 41, 62, 31, 3F. On each digit's lit cycles, `char_out` equals that entry (for example, while `an` = 0111, `char_out` = 8'h41).
- Push "W" as a fifth character → 8'h41 is discarded and `buf[3..0]` holds 62, 31, 3F, 57. Then push 8'h08 → `buf[3..0]` holds 20, 62, 31, 3F.
- Assert `clear` and `char_valid` ("Z") in the same cycle → all `buf` entries are 8'h20 and "Z" is not stored.
- Push during digit 0's lit period → `char_out` changes on the next cycle while `an` stays 1110. `an` and `digit_idx` timing is unaffected.
- Assert `reset` in a BLANK cycle of digit 2 → next cycle `an` = 1110, `digit_idx` = 0, `char_out` = 8'h20, and the buffer is blank. Rerun with BLANK_CYCLES = 0 → `an` goes directly from 1110 to 1101 with no all-off cycle.
